// File: rtl/conv_frame_loader.sv
// rtl/conv_frame_loader.sv - byte-stream frame loader for convolution input images and kernel sets
module conv_frame_loader #(
    parameter int DATA_SIZE        = 8,
    parameter int INPUT_SIZE       = 5,
    parameter int KERNEL_SIZE      = 3,
    parameter int IN_CHANNELS      = 1,
    parameter int OUT_CHANNELS     = 1,
    parameter int NUMBER_OF_INPUTS = 4,
    localparam int NI   = INPUT_SIZE * INPUT_SIZE * IN_CHANNELS,
    localparam int NK   = KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS * OUT_CHANNELS,
    localparam int IW   = (NUMBER_OF_INPUTS > 1) ? $clog2(NUMBER_OF_INPUTS) : 1,
    localparam int NMAX = (NI > NK) ? NI : NK,
    localparam int CW   = $clog2(NMAX + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      abort,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NI*DATA_SIZE-1:0]   in_bus,
    output logic [NK*DATA_SIZE-1:0]   kern_bus,
    output logic                      wr_in,
    output logic                      wr_kern,
    output logic [IW-1:0]             wr_index,
    output logic                      busy,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [7:0]                frame_count
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} state_t;

    state_t                   state, state_nxt;
    logic [NI*DATA_SIZE-1:0]  in_shadow;
    logic [NK*DATA_SIZE-1:0]  kern_shadow;
    logic [CW-1:0]            cnt;
    logic [7:0]               xsum;
    logic                     dest;
    logic [2:0]               idx;

    logic accept;
    logic hdr_sync_ok;
    logic hdr_idx_ok;
    logic last_byte;
    logic ck_ok;

    // abort beats any coincident byte, so it gates every acceptance
    assign accept      = in_valid && in_ready && !abort;
    assign hdr_sync_ok = (in_data[7:4] == 4'hA);
    assign hdr_idx_ok  = in_data[3] ? (in_data[2:0] == 3'd0)
                                    : (32'(in_data[2:0]) < NUMBER_OF_INPUTS);
    assign last_byte   = dest ? (cnt == CW'(NK - 1)) : (cnt == CW'(NI - 1));
    assign ck_ok       = (in_data == xsum);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state != COMMIT);
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (accept && hdr_sync_ok && hdr_idx_ok) state_nxt = PAYLOAD;
            PAYLOAD: if (accept && last_byte) state_nxt = CHECK;
            CHECK:   if (accept) state_nxt = ck_ok ? COMMIT : IDLE;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Buses and strobes are loaded on the checksum edge so they are visible during COMMIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_shadow   <= '0;
            kern_shadow <= '0;
            in_bus      <= '0;
            kern_bus    <= '0;
            cnt         <= '0;
            xsum        <= '0;
            dest        <= 1'b0;
            idx         <= '0;
            wr_in       <= 1'b0;
            wr_kern     <= 1'b0;
            wr_index    <= '0;
            err         <= 1'b0;
            err_code    <= 2'd0;
            frame_count <= 8'd0;
        end else begin
            wr_in   <= 1'b0;
            wr_kern <= 1'b0;
            err     <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!hdr_sync_ok) begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end else if (!hdr_idx_ok) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end else begin
                            dest <= in_data[3];
                            idx  <= in_data[2:0];
                            cnt  <= '0;
                            xsum <= '0;
                        end
                    end
                    PAYLOAD: begin
                        for (int i = 0; i < NI; i++)
                            if (!dest && cnt == CW'(i)) in_shadow[i*DATA_SIZE +: DATA_SIZE] <= in_data;
                        for (int i = 0; i < NK; i++)
                            if (dest && cnt == CW'(i)) kern_shadow[i*DATA_SIZE +: DATA_SIZE] <= in_data;
                        xsum <= xsum ^ in_data;
                        cnt  <= cnt + 1'b1;
                    end
                    CHECK: begin
                        if (ck_ok) begin
                            if (dest) begin
                                kern_bus <= kern_shadow;
                                wr_kern  <= 1'b1;
                            end else begin
                                in_bus   <= in_shadow;
                                wr_in    <= 1'b1;
                                wr_index <= IW'(idx);
                            end
                            frame_count <= frame_count + 8'd1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_loader.sv
// tb/tb_conv_frame_loader.sv - directed self-checking bench for conv_frame_loader
module tb_conv_frame_loader;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         abort;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] in_bus;
    logic [71:0]  kern_bus;
    logic         wr_in;
    logic         wr_kern;
    logic [1:0]   wr_index;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;
    logic [7:0]   frame_count;

    int checks   = 0;
    int failures = 0;

    logic [199:0] exp_in;
    logic [71:0]  ones_k;

    conv_frame_loader dut (
        .clk(clk), .reset_n(reset_n), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_bus(in_bus), .kern_bus(kern_bus),
        .wr_in(wr_in), .wr_kern(wr_kern), .wr_index(wr_index),
        .busy(busy), .err(err), .err_code(err_code), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit acc;
        acc = 1'b0;
        if (stall) idle_cycles($urandom_range(0, 2));
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            acc      = in_ready;
            @(posedge clk);
        end
        if (!acc) begin
            failures++;
            $error("FAIL handshake observed=not_accepted expected=accepted");
        end
    endtask

    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_input(input logic [2:0] idx, input logic [7:0] ck, input bit stall);
        send_byte({4'hA, 1'b0, idx}, stall);
        for (int k = 1; k <= 25; k++) send_byte(8'(k), stall);
        send_byte(ck, stall);
        settle();
    endtask

    task automatic send_kernel();
        send_byte(8'hA8, 1'b0);
        repeat (9) send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        settle();
    endtask

    initial begin
        for (int k = 0; k < 25; k++) exp_in[k*8 +: 8] = 8'(k + 1);
        ones_k   = '1;
        reset_n  = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_bus", in_bus, 0);
        chk("rst_kern_bus", kern_bus, 0);
        chk("rst_strobes", {wr_in, wr_kern, err}, 0);
        chk("rst_wr_index", wr_index, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_frame_count", frame_count, 0);
        reset_n = 1'b1;

        // good input frame, slot 2; bus must not move before the checksum
        send_byte(8'hA2, 1'b0);
        for (int k = 1; k <= 25; k++) send_byte(8'(k), 1'b0);
        settle();
        chk("pre_commit_in_bus", in_bus, 0);
        chk("pre_commit_busy", busy, 1);
        send_byte(8'h01, 1'b0);
        settle();
        chk("in_wr_in", wr_in, 1);
        chk("in_wr_kern", wr_kern, 0);
        chk("in_err", err, 0);
        chk("in_wr_index", wr_index, 2);
        chk("in_bus_lo", in_bus[7:0], 8'd1);
        chk("in_bus_hi", in_bus[199:192], 8'd25);
        chk("in_bus_all", in_bus, exp_in);
        chk("in_frame_count", frame_count, 1);
        chk("commit_in_ready", in_ready, 0);
        @(negedge clk);
        chk("in_wr_in_drop", wr_in, 0);
        chk("in_busy_idle", busy, 0);

        // good kernel frame
        send_kernel();
        chk("k_wr_kern", wr_kern, 1);
        chk("k_wr_in", wr_in, 0);
        chk("k_kern_bus", kern_bus, ones_k);
        chk("k_in_bus_kept", in_bus, exp_in);
        chk("k_frame_count", frame_count, 2);
        chk("k_wr_index_held", wr_index, 2);

        // bad checksum on slot 1
        send_input(3'd1, 8'h00, 1'b0);
        chk("ck_err", err, 1);
        chk("ck_err_code", err_code, 3);
        chk("ck_wr_in", wr_in, 0);
        chk("ck_busy", busy, 0);
        chk("ck_frame_count", frame_count, 2);
        chk("ck_wr_index", wr_index, 2);
        chk("ck_in_bus", in_bus, exp_in);
        @(negedge clk);
        chk("ck_err_drop", err, 0);
        chk("ck_err_code_held", err_code, 3);

        // header rejects
        send_byte(8'h52, 1'b0); settle();
        chk("h52_err", err, 1);
        chk("h52_code", err_code, 1);
        chk("h52_busy", busy, 0);
        send_byte(8'hA5, 1'b0); settle();
        chk("hA5_err", err, 1);
        chk("hA5_code", err_code, 2);
        chk("hA5_busy", busy, 0);
        send_byte(8'hA4, 1'b0); settle();
        chk("hA4_code", {err, err_code}, 3'b110);
        send_byte(8'hA9, 1'b0); settle();
        chk("hA9_err", err, 1);
        chk("hA9_code", err_code, 2);
        chk("hA9_busy", busy, 0);
        send_input(3'd3, 8'h01, 1'b0);
        chk("after_rej_wr_in", wr_in, 1);
        chk("after_rej_idx", wr_index, 3);
        chk("after_rej_count", frame_count, 3);

        // stalled frame, slot 0
        send_input(3'd0, 8'h01, 1'b1);
        chk("stall_wr_in", wr_in, 1);
        chk("stall_idx", wr_index, 0);
        chk("stall_in_bus", in_bus, exp_in);
        chk("stall_count", frame_count, 4);

        // abort coincident with payload byte 11
        send_byte(8'hA1, 1'b0);
        for (int k = 1; k <= 10; k++) send_byte(8'(k), 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd11;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_strobes", {wr_in, wr_kern, err}, 0);
        chk("abort_count", frame_count, 4);
        send_input(3'd1, 8'h01, 1'b0);
        chk("post_abort_wr_in", wr_in, 1);
        chk("post_abort_idx", wr_index, 1);
        chk("post_abort_count", frame_count, 5);

        // reset mid-payload
        send_byte(8'hA2, 1'b0);
        for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("mrst_state", {in_ready, busy}, 2'b10);
        chk("mrst_in_bus", in_bus, 0);
        chk("mrst_kern_bus", kern_bus, 0);
        chk("mrst_strobes", {wr_in, wr_kern, err}, 0);
        chk("mrst_wr_index", wr_index, 0);
        chk("mrst_err_code", err_code, 0);
        chk("mrst_count", frame_count, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // first byte after reset is a header; then wrap the frame counter
        send_kernel();
        chk("wrap_first_kern", wr_kern, 1);
        chk("wrap_first_count", frame_count, 1);
        for (int f = 2; f <= 255; f++) send_kernel();
        chk("wrap_255", frame_count, 255);
        send_kernel();
        chk("wrap_0", frame_count, 0);
        chk("wrap_in_bus", in_bus, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_frame_loader.md
CONV_FRAME_LOADER -- requirements
Module: conv_frame_loader

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, element width; only 8 is supported.
REQ-002 SHALL have parameter INPUT_SIZE, default 5, input image rows and columns.
REQ-003 SHALL have parameter KERNEL_SIZE, default 3, kernel rows and columns.
REQ-004 SHALL have parameter IN_CHANNELS, default 1; parameter OUT_CHANNELS, default 1; parameter NUMBER_OF_INPUTS, default 4, number of input buffer slots.
REQ-005 SHALL have derived widths: NI = INPUT_SIZE*INPUT_SIZE*IN_CHANNELS elements; NK = KERNEL_SIZE*KERNEL_SIZE*IN_CHANNELS*OUT_CHANNELS elements.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 abort  input  1  synchronous frame abort.
REQ-009 in_data  input  8  stream byte.
REQ-010 in_valid  input  1  in_data is valid.
REQ-011 in_ready  output  1  loader accepts a byte; the transfer occurs when in_valid && in_ready.
REQ-012 in_bus  output  NI*DATA_SIZE  assembled input image.
REQ-013 kern_bus  output  NK*DATA_SIZE  assembled kernel set.
REQ-014 wr_in  output  1  one-cycle strobe: in_bus is valid for slot wr_index.
REQ-015 wr_kern  output  1  one-cycle strobe: kern_bus is valid.
REQ-016 wr_index  output  $clog2(NUMBER_OF_INPUTS)  destination input slot.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 err  output  1  one-cycle error strobe.
REQ-019 err_code  output  2  1=bad sync, 2=bad index, 3=checksum mismatch; held until the next err.
REQ-020 frame_count  output  8  count of committed frames; wraps from 255 to 0.

Function
REQ-021 SHALL parse each frame as a header byte, then payload bytes, then a checksum byte.
- Header format: bits [7:4] = 4'hA (sync); bit [3] = destination (0 = input, 1 = kernel); bits [2:0] = index.
REQ-022 SHALL have FSM states IDLE, PAYLOAD, CHECK and COMMIT.
REQ-023 SHALL drive in_ready high in IDLE, PAYLOAD and CHECK, and low in COMMIT.
REQ-024 In IDLE, on an accepted header byte, the FSM SHALL behave as follows:
- Sync not equal to 4'hA: err pulse, err_code=1, stay in IDLE.
- Destination is input and index >= NUMBER_OF_INPUTS: err pulse, err_code=2, stay in IDLE.
- Destination is kernel and index != 0: err pulse, err_code=2, stay in IDLE.
- Otherwise: latch the destination and index, clear the byte counter and running XOR, go to PAYLOAD.
REQ-025 In PAYLOAD, accepted byte k (0-based) SHALL be written to bits [(k+1)*8-1 : k*8] of a shadow register, and the running XOR SHALL be updated.
- After byte NI-1 (input) or NK-1 (kernel), the FSM SHALL go to CHECK.
REQ-026 The shadow registers SHALL be internal; in_bus and kern_bus SHALL change only on commit.
REQ-027 In CHECK, on an accepted byte:
- Byte equals the running XOR: go to COMMIT.
- Otherwise: err pulse, err_code=3, go to IDLE, and leave outputs and frame_count unchanged.
REQ-028 In COMMIT (exactly one cycle), the block SHALL:
- load the destination bus from its shadow register;
- pulse wr_in with wr_index set to the latched index, or pulse wr_kern;
- increment frame_count;
- then go to IDLE.
REQ-029 Latency: the wr_in/wr_kern strobe and the updated bus SHALL appear in the cycle after the checksum byte is accepted.
REQ-030 wr_index SHALL hold its last committed value between frames.
REQ-031 Stalls: cycles with in_valid low SHALL not advance state or the byte counter, with no timeout.
REQ-032 abort high SHALL force IDLE next cycle from any state, discarding the partial frame with no err and no write.
- If abort coincides with an accepted byte, abort SHALL win and the byte is dropped.
REQ-033 abort asserted during COMMIT SHALL NOT suppress that cycle's commit; the FSM SHALL return to IDLE as normal.
REQ-034 err, wr_in and wr_kern SHALL never be high in the same cycle.

Reset
REQ-035 While reset_n is low, the block SHALL hold the following values, taking effect asynchronously:
- state=IDLE, in_ready=1, busy=0;
- in_bus=0, kern_bus=0, shadow registers=0;
- wr_in=0, wr_kern=0, wr_index=0;
- err=0, err_code=0, frame_count=0.
REQ-036 Reset asserted mid-frame SHALL discard the frame; the first byte accepted after release SHALL be parsed as a header.

Verification
REQ-037 Good input frame: header 8'hA2, payload bytes 1..25, checksum 8'h01 (XOR of 1..25) -> wr_in pulses one cycle after the checksum with wr_index=2, in_bus[7:0]=1, in_bus[199:192]=25, frame_count=1.
REQ-038 Good kernel frame: header 8'hA8, nine payload bytes 8'hFF, checksum 8'hFF -> wr_kern pulse, kern_bus all ones; in_bus unchanged.
REQ-039 Bad checksum: a good input frame with checksum 8'h00 -> err pulse, err_code=3, no wr_in, in_bus and frame_count unchanged.
REQ-040 Header rejects: 8'h52 -> err_code=1; 8'hA5 -> err_code=2; 8'hA9 -> err_code=2; in every case the FSM stays in IDLE, and a good frame sent immediately after succeeds.
REQ-041 Stall and abort: toggle in_valid randomly during a good frame -> identical result to the unstalled frame; abort after payload byte 10 -> no strobes, busy=0 next cycle, and the following good frame commits.
REQ-042 Reset mid-payload and counter wrap: reset_n low after payload byte 5 -> all REQ-035 values immediately; 256 good frames -> frame_count returns to 0.
